coin_acceptor: RTL and testbench

Front-end stage for `vending_machine`. It synchronises and debounces the two raw coin-sensor lines and queues detected coins in a 2-entry FIFO. Each coin is presented to `vending_machine` as a single-cycle code on the 2-bit coin input: 0 = none, 1 = 5-unit coin, 2 = 10-unit coin. Coins that arrive while the machine is disabled, or while the queue is full, are diverted to the return chute via `reject`.

---
 rtl/coin_acceptor.sv | 147 ++++++++++++++
 tb/tb_coin_acceptor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin sensor front end: 2-flop synchronisers, per-channel debounce, 2-entry coin FIFO, paced code output.
// Optional emitted-value tally register enabled by defining COIN_ACCEPTOR_TALLY_EN.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    input  logic       enable,
    output logic [1:0] coin_code,
    output logic       reject
`ifdef COIN_ACCEPTOR_TALLY_EN
    ,
    output logic [7:0] tally
`endif
);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

    // bit 0 = 5-unit channel, bit 1 = 10-unit channel
    logic [1:0] sync_m, sync_s, d, d_q, ev;
    logic [3:0] cnt [2];

    logic [1:0] mem;
    logic       wp, rp;
    logic [1:0] count, free;
    logic       head;

    logic       push5, push10, rej5, rej10, rej_pend;
    logic       pop, can_pop, gap_last;
    logic [2:0] gap_cnt;
    state_t     state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_m <= '0;
            sync_s <= '0;
            d      <= '0;
            d_q    <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync_m <= {coin10_raw, coin5_raw};
            sync_s <= sync_m;
            d_q    <= d;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync_s[i] == d[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    d[i]   <= sync_s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    assign ev   = d & ~d_q;
    assign head = mem[rp];

    // A same-cycle pop counts as a free slot; the 5-unit coin claims space first.
    always_comb begin
        free   = 2'd2 - count + 2'(pop);
        push5  = ev[0] & enable & (free != 2'd0);
        push10 = ev[1] & enable & (free > 2'(push5));
        rej5   = ev[0] & ~push5;
        rej10  = ev[1] & ~push10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem      <= '0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            count    <= '0;
            rej_pend <= 1'b0;
            reject   <= 1'b0;
        end else begin
            if (push5)  mem[wp] <= 1'b0;
            if (push10) mem[wp ^ push5] <= 1'b1;
            wp       <= wp ^ (push5 ^ push10);
            rp       <= rp ^ pop;
            count    <= count + 2'(push5) + 2'(push10) - 2'(pop);
            rej_pend <= rej5 & rej10;
            reject   <= rej5 | rej10 | rej_pend;
        end
    end

    assign can_pop  = enable & (count != 2'd0);
    assign gap_last = (gap_cnt == GAP_LAST);

    // The last GAP cycle may pop directly so codes can repeat every 1+GAP_CYCLES cycles.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_pop) begin
                    pop       = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: state_nxt = GAP;
            GAP: begin
                if (gap_last) begin
                    if (can_pop) begin
                        pop       = 1'b1;
                        state_nxt = EMIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            coin_code <= '0;
        end else begin
            state     <= state_nxt;
            coin_code <= pop ? (head ? 2'd2 : 2'd1) : 2'd0;
            if (state != GAP)  gap_cnt <= '0;
            else if (!gap_last) gap_cnt <= gap_cnt + 3'd1;
        end
    end

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [8:0] tally_sum;
    assign tally_sum = {1'b0, tally} + {7'b0, coin_code};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     tally <= '0;
        else if (coin_code != 2'd0)  tally <= tally_sum[8] ? 8'hFF : tally_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random sensor traffic against a reference model.
// Tally checks are compiled in when COIN_ACCEPTOR_TALLY_EN is defined.
`timescale 1ns/1ps
module tb_coin_acceptor;

    localparam int DEB = 4;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin5_raw = 1'b0;
    logic       coin10_raw = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] coin_code;
    logic       reject;
`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [7:0] tally;
`endif

    coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .enable     (enable),
        .coin_code  (coin_code),
        .reject     (reject)
`ifdef COIN_ACCEPTOR_TALLY_EN
        ,
        .tally      (tally)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw-sample history, coin queue and an earliest-next-emit edge number.
    int  cyc = 0;
    bit  h5 [32];
    bit  h10 [32];
    bit  md5, md10, mr5, mr10, mpend, exp_rej;
    bit  q [$];
    int  next_pop, exp_code, exp_tally;

    function automatic bit settled(input bit h [32], input bit v);
        for (int j = 2; j <= DEB + 1; j++)
            if (h[j] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            h5[i]  = 1'b0;
            h10[i] = 1'b0;
        end
        md5 = 0; md10 = 0; mr5 = 0; mr10 = 0; mpend = 0; exp_rej = 0;
        q.delete();
        next_pop = 0; exp_code = 0; exp_tally = 0;
    endtask

    task automatic model_step();
        bit ev5, ev10;
        int freec, r;
        exp_tally += exp_code;
        if (exp_tally > 255) exp_tally = 255;
        ev5  = mr5;
        ev10 = mr10;
        for (int i = 31; i > 0; i--) begin
            h5[i]  = h5[i-1];
            h10[i] = h10[i-1];
        end
        h5[0]  = coin5_raw;
        h10[0] = coin10_raw;
        mr5 = 0;
        if (settled(h5, !md5)) begin md5 = !md5; mr5 = md5; end
        mr10 = 0;
        if (settled(h10, !md10)) begin md10 = !md10; mr10 = md10; end
        exp_code = 0;
        if (cyc >= next_pop && q.size() > 0 && enable) begin
            exp_code = q.pop_front() ? 2 : 1;
            next_pop = cyc + 1 + GAP;
        end
        freec = 2 - q.size();
        r = 0;
        if (ev5) begin
            if (enable && freec > 0) begin q.push_back(1'b0); freec--; end
            else r++;
        end
        if (ev10) begin
            if (enable && freec > 0) begin q.push_back(1'b1); freec--; end
            else r++;
        end
        exp_rej = (r > 0) || mpend;
        mpend   = (r == 2);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) model_reset();
        else     model_step();
    end

    int n_c1 = 0, n_c2 = 0, n_rej = 0;

    always @(negedge clk) begin
        check("coin_code", int'(coin_code), exp_code);
        check("reject", int'(reject), int'(exp_rej));
`ifdef COIN_ACCEPTOR_TALLY_EN
        check("tally", int'(tally), exp_tally);
`endif
        if (coin_code == 2'd1) n_c1++;
        if (coin_code == 2'd2) n_c2++;
        if (reject) n_rej++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int b, t1, t2, v1, v2, c1, c2, rj;
        bit l5, l10;
        int r5, r10;
        model_reset();
        #6 rst = 1'b0;

        // reset state and a clean 10-unit pulse
        @(negedge clk);
        enable = 1'b1;
        check("rst_code", int'(coin_code), 0);
        check("rst_reject", int'(reject), 0);
        tick(2);
        c2 = n_c2; rj = n_rej;
        b = cyc + 1; coin10_raw = 1'b1; t1 = -1; v1 = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (coin_code != 2'd0 && t1 < 0) begin t1 = cyc; v1 = coin_code; end
        end
        coin10_raw = 1'b0;
        tick(15);
        check("clean_latency", t1, b + 3 + DEB);
        check("clean_code", v1, 2);
        check("clean_count", n_c2 - c2, 1);
        check("clean_reject", n_rej - rj, 0);

        // bounce shorter than the debounce window, then a clean 5-unit coin
        c1 = n_c1; c2 = n_c2; rj = n_rej;
        for (int i = 0; i < 6; i++) begin
            coin5_raw = ~coin5_raw;
            tick(1);
        end
        coin5_raw = 1'b0;
        tick(20);
        check("bounce_codes", (n_c1 - c1) + (n_c2 - c2), 0);
        check("bounce_reject", n_rej - rj, 0);
        coin5_raw = 1'b1;
        tick(8);
        coin5_raw = 1'b0;
        tick(20);
        check("bounce_clean", n_c1 - c1, 1);

        // simultaneous coins
        rj = n_rej; t1 = -1; t2 = -1; v1 = -1; v2 = -1;
        coin5_raw = 1'b1; coin10_raw = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 8) begin coin5_raw = 1'b0; coin10_raw = 1'b0; end
            if (coin_code != 2'd0) begin
                if (t1 < 0) begin t1 = cyc; v1 = coin_code; end
                else if (t2 < 0) begin t2 = cyc; v2 = coin_code; end
            end
        end
        check("simul_first", v1, 1);
        check("simul_second", v2, 2);
        check("simul_spacing", t2 - t1, 3);
        check("simul_reject", n_rej - rj, 0);

        // full FIFO: hold two coins with enable low, then a pair arrives as enable returns
        c1 = n_c1; c2 = n_c2; rj = n_rej;
        b = cyc + 1; coin5_raw = 1'b1; coin10_raw = 1'b1;
        while (cyc < b + 6) @(negedge clk);
        enable = 1'b0;
        while (cyc < b + 8) @(negedge clk);
        coin5_raw = 1'b0; coin10_raw = 1'b0;
        tick(12);
        b = cyc + 1; coin5_raw = 1'b1; coin10_raw = 1'b1;
        while (cyc < b + 5) @(negedge clk);
        enable = 1'b1;
        while (cyc < b + 8) @(negedge clk);
        coin5_raw = 1'b0; coin10_raw = 1'b0;
        tick(30);
        check("full_reject", n_rej - rj, 1);
        check("full_codes", (n_c1 - c1) + (n_c2 - c2), 3);

        // disabled: coin rejected and never queued
        c1 = n_c1; c2 = n_c2; rj = n_rej;
        enable = 1'b0;
        coin5_raw = 1'b1;
        tick(8);
        coin5_raw = 1'b0;
        tick(20);
        check("dis_reject", n_rej - rj, 1);
        enable = 1'b1;
        tick(20);
        check("dis_codes", (n_c1 - c1) + (n_c2 - c2), 0);

        // random sensor traffic with occasional enable changes
        l5 = 0; l10 = 0; r5 = 3; r10 = 7;
        for (int i = 0; i < 3000; i++) begin
            if (r5 == 0) begin l5 = !l5; r5 = $urandom_range(1, 14); end
            if (r10 == 0) begin l10 = !l10; r10 = $urandom_range(1, 14); end
            r5--; r10--;
            coin5_raw = l5; coin10_raw = l10;
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            tick(1);
        end
        coin5_raw = 1'b0; coin10_raw = 1'b0; enable = 1'b1;
        tick(30);

        // reset during EMIT with one coin still queued
        t1 = -1;
        coin5_raw = 1'b1; coin10_raw = 1'b1;
        for (int i = 0; i < 20 && t1 < 0; i++) begin
            @(negedge clk);
            if (coin_code != 2'd0) t1 = cyc;
        end
        check("rstmid_seen", int'(t1 >= 0), 1);
        #2 rst = 1'b1;
        model_reset();
        #1 check("rstmid_code", int'(coin_code), 0);
        @(negedge clk);
        coin5_raw = 1'b0; coin10_raw = 1'b0;
        rst = 1'b0;
        c1 = n_c1; c2 = n_c2; rj = n_rej;
        tick(20);
        check("rstmid_codes", (n_c1 - c1) + (n_c2 - c2), 0);
        check("rstmid_reject", n_rej - rj, 0);

`ifdef COIN_ACCEPTOR_TALLY_EN
        for (int i = 0; i < 130; i++) begin
            coin10_raw = 1'b1;
            tick(6);
            coin10_raw = 1'b0;
            tick(6);
        end
        tick(30);
        check("tally_sat", int'(tally), 255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
